// File: rtl/lcd_pkg.sv
// Shared HD44780 command bytes, display-word field layout and FSM state types
// for the character-LCD writer.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] SET_DDRAM     = 8'h80;
    localparam logic [7:0] LINE2_OFS     = 8'h40;

    localparam int WORD_W    = 18;
    localparam int CHR_W     = 8;
    localparam int CHR_A_LSB = 10;
    localparam int CHR_B_LSB = 2;
    localparam int SLOT_LSB  = 0;
    localparam int SLOT_W    = 2;
    localparam int INIT_LEN  = 4;

    typedef enum logic [2:0] {
        S_PWRUP,
        S_INIT,
        S_IDLE,
        S_ADDR,
        S_CHR_A,
        S_CHR_B
    } topState_t;

    typedef enum logic [1:0] {
        X_IDLE,
        X_SETUP,
        X_PULSE,
        X_WAIT
    } xferState_t;

    function automatic logic [7:0] initByte(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = FUNC_SET_8B2L;
            2'd1:    b = DISP_ON;
            2'd2:    b = CLEAR;
            default: b = ENTRY_INC;
        endcase
        return b;
    endfunction

    // Each slot covers two columns, so slot 3 lands on column 6.
    function automatic logic [7:0] ddramAddr(input logic lineSel, input logic [SLOT_W-1:0] slot);
        logic [7:0] ofs;
        ofs = lineSel ? LINE2_OFS : 8'h00;
        return SET_DDRAM | ofs | {5'b00000, slot, 1'b0};
    endfunction

endpackage

// File: rtl/lcd_byte_xfer.sv
// Moves one byte onto the HD44780 bus: setup cycle, E pulse, then a hold-off
// whose length depends on whether the byte was a clear-display command.
module lcd_byte_xfer
    import lcd_pkg::*;
#(
    parameter int E_HIGH_CYC = 1,
    parameter int T_CMD_CYC  = 1,
    parameter int T_CLR_CYC  = 20
) (
    input  logic       clk,
    input  logic       rstBt,
    input  logic       start,
    input  logic [7:0] byteIn,
    input  logic       rsIn,
    input  logic       longWait,
    output logic       enable,
    output logic [7:0] dataOut,
    output logic       rsOut,
    output logic       done
);

    localparam int MAX_A   = (E_HIGH_CYC > T_CMD_CYC) ? E_HIGH_CYC : T_CMD_CYC;
    localparam int MAX_CYC = (MAX_A > T_CLR_CYC) ? MAX_A : T_CLR_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    xferState_t    state;
    xferState_t    nextState;
    logic [CW-1:0] cnt;
    logic [CW-1:0] waitLast;
    logic          longReg;

    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            state <= X_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Bus byte and RS are captured at start and held until the next start.
    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            dataOut <= '0;
            rsOut   <= 1'b0;
            longReg <= 1'b0;
        end else if (state == X_IDLE && start) begin
            dataOut <= byteIn;
            rsOut   <= rsIn;
            longReg <= longWait;
        end
    end

    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            cnt <= '0;
        end else if (state != nextState) begin
            cnt <= '0;
        end else if (state == X_PULSE || state == X_WAIT) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign waitLast = longReg ? CW'(T_CLR_CYC - 1) : CW'(T_CMD_CYC - 1);

    always_comb begin
        nextState = state;
        case (state)
            X_IDLE:  if (start) nextState = X_SETUP;
            X_SETUP: nextState = X_PULSE;
            X_PULSE: if (cnt == CW'(E_HIGH_CYC - 1)) nextState = X_WAIT;
            X_WAIT:  if (cnt == waitLast) nextState = X_IDLE;
            default: nextState = X_IDLE;
        endcase
    end

    always_comb begin
        enable = (state == X_PULSE);
        done   = (state == X_WAIT) && (cnt == waitLast);
    end

endmodule

// File: rtl/lcd_hd44780_writer.sv
// HD44780 8-bit bus writer: runs the power-up init, then turns each accepted
// display word into a DDRAM address command followed by two characters.
module lcd_hd44780_writer
    import lcd_pkg::*;
#(
    parameter int T_PWRUP_CYC = 150,
    parameter int E_HIGH_CYC  = 1,
    parameter int T_CMD_CYC   = 1,
    parameter int T_CLR_CYC   = 20
) (
    input  logic              clk,
    input  logic              rstBt,
    input  logic              lcdWrite,
    input  logic [WORD_W-1:0] dataIn,
    input  logic              line,
    input  logic              setLine,
    output logic [7:0]        dataOut,
    output logic              RS,
    output logic              RW,
    output logic              enableOut,
    output logic              ready,
    output logic              busy
);

    localparam int PW = $clog2(T_PWRUP_CYC + 1);

    topState_t         state;
    topState_t         nextState;
    logic [2:0]        wrSync;
    logic [1:0]        setSync;
    logic              wrRise;
    logic              lineReg;
    logic              lineNow;
    logic              wordLine;
    logic [CHR_W-1:0]  chrA;
    logic [CHR_W-1:0]  chrB;
    logic [SLOT_W-1:0] slot;
    logic [PW-1:0]     pwrCnt;
    logic [1:0]        initIdx;
    logic              issued;
    logic              byteState;
    logic              xStart;
    logic [7:0]        xByte;
    logic              xRs;
    logic              xLong;
    logic              xDone;

    // wrSync[2] is the previous synchronised level, used only for edge detection.
    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            wrSync  <= '0;
            setSync <= '0;
        end else begin
            wrSync  <= {wrSync[1:0], lcdWrite};
            setSync <= {setSync[0], setLine};
        end
    end

    assign wrRise  = wrSync[1] & ~wrSync[2];
    assign lineNow = setSync[1] ? line : lineReg;

    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            state <= S_PWRUP;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            S_PWRUP: if (pwrCnt == PW'(T_PWRUP_CYC - 1)) nextState = S_INIT;
            S_INIT:  if (xDone && initIdx == 2'(INIT_LEN - 1)) nextState = S_IDLE;
            S_IDLE:  if (wrRise) nextState = S_ADDR;
            S_ADDR:  if (xDone) nextState = S_CHR_A;
            S_CHR_A: if (xDone) nextState = S_CHR_B;
            S_CHR_B: if (xDone) nextState = S_IDLE;
            default: nextState = S_PWRUP;
        endcase
    end

    // A word is captured with the line in force at acceptance; later setLine
    // pulses only affect the next word.
    always_ff @(posedge clk or negedge rstBt) begin
        if (!rstBt) begin
            lineReg  <= 1'b0;
            wordLine <= 1'b0;
            chrA     <= '0;
            chrB     <= '0;
            slot     <= '0;
            pwrCnt   <= '0;
            initIdx  <= '0;
            issued   <= 1'b0;
        end else begin
            if (setSync[1]) begin
                lineReg <= line;
            end
            if (state == S_IDLE && wrRise) begin
                chrA     <= dataIn[CHR_A_LSB +: CHR_W];
                chrB     <= dataIn[CHR_B_LSB +: CHR_W];
                slot     <= dataIn[SLOT_LSB +: SLOT_W];
                wordLine <= lineNow;
            end
            if (state == S_PWRUP) begin
                pwrCnt <= pwrCnt + PW'(1);
            end
            if (state == S_INIT && xDone) begin
                initIdx <= initIdx + 2'd1;
            end
            if (xStart) begin
                issued <= 1'b1;
            end else if (xDone) begin
                issued <= 1'b0;
            end
        end
    end

    always_comb begin
        byteState = 1'b0;
        xByte     = 8'h00;
        xRs       = 1'b0;
        xLong     = 1'b0;
        ready     = 1'b0;
        case (state)
            S_INIT: begin
                byteState = 1'b1;
                xByte     = initByte(initIdx);
                xLong     = (initByte(initIdx) == CLEAR);
            end
            S_IDLE: ready = 1'b1;
            S_ADDR: begin
                byteState = 1'b1;
                xByte     = ddramAddr(wordLine, slot);
            end
            S_CHR_A: begin
                byteState = 1'b1;
                xByte     = chrA;
                xRs       = 1'b1;
            end
            S_CHR_B: begin
                byteState = 1'b1;
                xByte     = chrB;
                xRs       = 1'b1;
            end
            default: ;
        endcase
        xStart = byteState && !issued;
    end

    assign busy = ~ready;
    assign RW   = 1'b0;

    lcd_byte_xfer #(
        .E_HIGH_CYC (E_HIGH_CYC),
        .T_CMD_CYC  (T_CMD_CYC),
        .T_CLR_CYC  (T_CLR_CYC)
    ) u_xfer (
        .clk      (clk),
        .rstBt    (rstBt),
        .start    (xStart),
        .byteIn   (xByte),
        .rsIn     (xRs),
        .longWait (xLong),
        .enable   (enableOut),
        .dataOut  (dataOut),
        .rsOut    (RS),
        .done     (xDone)
    );

endmodule

// File: tb/tb_lcd_hd44780_writer.sv
// Self-checking bench for lcd_hd44780_writer: a cycle-timeline model of the LCD
// bus checked every cycle, plus literal expectations for the key sequences.
module tb_lcd_hd44780_writer;

    localparam int T_PWRUP = 150;
    localparam int E_HIGH  = 1;
    localparam int T_CMD   = 1;
    localparam int T_CLR   = 20;
    localparam int HN      = 8192;

    logic        clk      = 1'b0;
    logic        rstBt    = 1'b0;
    logic        lcdWrite = 1'b0;
    logic        line     = 1'b0;
    logic        setLine  = 1'b0;
    logic [17:0] dataIn   = '0;
    logic [7:0]  dataOut;
    logic        RS;
    logic        RW;
    logic        enableOut;
    logic        ready;
    logic        busy;

    int errCount   = 0;
    int checkCount = 0;

    lcd_hd44780_writer #(
        .T_PWRUP_CYC (T_PWRUP),
        .E_HIGH_CYC  (E_HIGH),
        .T_CMD_CYC   (T_CMD),
        .T_CLR_CYC   (T_CLR)
    ) dut (
        .clk       (clk),
        .rstBt     (rstBt),
        .lcdWrite  (lcdWrite),
        .dataIn    (dataIn),
        .line      (line),
        .setLine   (setLine),
        .dataOut   (dataOut),
        .RS        (RS),
        .RW        (RW),
        .enableOut (enableOut),
        .ready     (ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        bit         rs;
        bit         isLong;
    } busByte_t;

    // Model: per-cycle input history and the expected E-high timeline.
    int         cyc;
    bit         wH[HN];
    bit         slH[HN];
    bit         lnH[HN];
    bit         expHi[HN];
    logic [7:0] expB[HN];
    bit         expR[HN];
    int         readyFrom;
    bit         lineRegM;
    bit         prevE;
    bit         prevReady;
    int         readyRise;
    logic [7:0] logB[$];
    bit         logR[$];
    int         logCyc[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic bit histW(input int k);
        return (k >= 1 && k < HN) ? wH[k] : 1'b0;
    endfunction

    function automatic bit histS(input int k);
        return (k >= 1 && k < HN) ? slH[k] : 1'b0;
    endfunction

    function automatic logic [8:0] getLog(input int i);
        if (i < logB.size()) return {logR[i], logB[i]};
        return 9'h1FF;
    endfunction

    function automatic int getCyc(input int i);
        if (i < logCyc.size()) return logCyc[i];
        return -1;
    endfunction

    // Bytes follow each other every E_HIGH + wait + 2 cycles (setup plus handoff);
    // the writer is ready again the cycle after the last wait cycle.
    task automatic scheduleBytes(input int aFirst, input busByte_t seq[$], output int rdy);
        int a;
        int t;
        a   = aFirst;
        rdy = aFirst;
        foreach (seq[i]) begin
            t = seq[i].isLong ? T_CLR : T_CMD;
            for (int k = 0; k < E_HIGH; k++) begin
                if (a + k < HN) begin
                    expHi[a + k] = 1'b1;
                    expB[a + k]  = seq[i].b;
                    expR[a + k]  = seq[i].rs;
                end
            end
            rdy = a + E_HIGH + t;
            a   = rdy + 2;
        end
    endtask

    task automatic modelReset();
        busByte_t q[$];
        cyc       = 0;
        lineRegM  = 1'b0;
        prevE     = 1'b0;
        prevReady = 1'b0;
        for (int i = 0; i < HN; i++) begin
            wH[i]    = 1'b0;
            slH[i]   = 1'b0;
            lnH[i]   = 1'b0;
            expHi[i] = 1'b0;
            expB[i]  = 8'h00;
            expR[i]  = 1'b0;
        end
        q.push_back('{b: 8'h38, rs: 1'b0, isLong: 1'b0});
        q.push_back('{b: 8'h0C, rs: 1'b0, isLong: 1'b0});
        q.push_back('{b: 8'h01, rs: 1'b0, isLong: 1'b1});
        q.push_back('{b: 8'h06, rs: 1'b0, isLong: 1'b0});
        scheduleBytes(T_PWRUP + 2, q, readyFrom);
    endtask

    // Edge n sees the lcdWrite/setLine levels sampled two edges earlier.
    task automatic modelEdge(input int n, input logic [17:0] din);
        busByte_t   q[$];
        bit         rise;
        bit         slS;
        bit         lineEff;
        logic [7:0] addr;
        rise    = histW(n - 2) && !histW(n - 3);
        slS     = histS(n - 2);
        lineEff = slS ? lnH[n] : lineRegM;
        if (slS) lineRegM = lnH[n];
        if (rise && (n - 1) >= readyFrom) begin
            addr = 8'h80 + (lineEff ? 8'h40 : 8'h00) + 8'(2 * din[1:0]);
            q.push_back('{b: addr, rs: 1'b0, isLong: 1'b0});
            q.push_back('{b: din[17:10], rs: 1'b1, isLong: 1'b0});
            q.push_back('{b: din[9:2], rs: 1'b1, isLong: 1'b0});
            scheduleBytes(n + 2, q, readyFrom);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rstBt) begin
                modelReset();
            end else begin
                cyc++;
                if (cyc < HN) begin
                    wH[cyc]  = lcdWrite;
                    slH[cyc] = setLine;
                    lnH[cyc] = line;
                end
                modelEdge(cyc, dataIn);
            end
            #1;
            if (!rstBt) begin
                checkOutput("rstE", enableOut, 0);
                checkOutput("rstData", dataOut, 0);
                checkOutput("rstRS", RS, 0);
                checkOutput("rstRW", RW, 0);
                checkOutput("rstReady", ready, 0);
                checkOutput("rstBusy", busy, 1);
            end else begin
                bit eHi;
                eHi = (cyc < HN) ? expHi[cyc] : 1'b0;
                checkOutput("busE", enableOut, eHi);
                checkOutput("RW", RW, 0);
                checkOutput("ready", ready, cyc >= readyFrom);
                checkOutput("busy", busy, cyc < readyFrom);
                if (eHi) begin
                    checkOutput("busData", dataOut, expB[cyc]);
                    checkOutput("busRS", RS, expR[cyc]);
                end
                if (enableOut && !prevE) begin
                    logB.push_back(dataOut);
                    logR.push_back(RS);
                    logCyc.push_back(cyc);
                end
                if (ready && !prevReady) readyRise = cyc;
                prevE     = enableOut;
                prevReady = ready;
            end
        end
    end

    task automatic applyStimulus(input logic wr, input logic [17:0] din, input logic ln,
                                 input logic sl, input int nCyc);
        @(negedge clk);
        lcdWrite = wr;
        dataIn   = din;
        line     = ln;
        setLine  = sl;
        if (nCyc > 1) repeat (nCyc - 1) @(negedge clk);
    endtask

    task automatic waitReady(input int maxCyc, input string name);
        for (int i = 0; i < maxCyc; i++) begin
            if (ready) break;
            @(negedge clk);
        end
        checkOutput(name, ready, 1);
    endtask

    task automatic waitEnable(input int maxCyc, input string name);
        for (int i = 0; i < maxCyc; i++) begin
            if (enableOut) break;
            @(negedge clk);
        end
        checkOutput(name, enableOut, 1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errCount);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int k;

        repeat (3) @(negedge clk);
        checkOutput("resetBusy", busy, 1);
        checkOutput("resetReady", ready, 0);
        rstBt = 1'b1;

        // Init sequence with a request pulse during power-up that must be dropped.
        applyStimulus(0, 18'h0, 0, 0, 20);
        applyStimulus(1, 18'h3FFFF, 0, 0, 5);
        applyStimulus(0, 18'h0, 0, 0, 1);
        waitReady(400, "initReady");
        checkOutput("initCount", logB.size(), 4);
        checkOutput("init0", getLog(0), 9'h038);
        checkOutput("init1", getLog(1), 9'h00C);
        checkOutput("init2", getLog(2), 9'h001);
        checkOutput("init3", getLog(3), 9'h006);
        checkOutput("firstEcycle", getCyc(0), 152);
        checkOutput("secondEcycle", getCyc(1), 156);
        checkOutput("gapAfterClear", getCyc(3) - getCyc(2) - E_HIGH, T_CLR + 2);
        checkOutput("initReadyCycle", readyRise, 185);

        // Word on line 0, slot 1; measure edge-to-E latency.
        base = logB.size();
        @(negedge clk);
        dataIn   = 18'b000111000111000001;
        line     = 1'b0;
        lcdWrite = 1'b1;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            k++;
            if (enableOut) break;
        end
        checkOutput("latency", k - 1, 4);
        waitReady(100, "word1Ready");
        checkOutput("word1Addr", getLog(base), 9'h082);
        checkOutput("word1ChrA", getLog(base + 1), 9'h11C);
        checkOutput("word1ChrB", getLog(base + 2), 9'h170);

        // setLine to the bottom line, then write slot 3.
        applyStimulus(0, 18'h0, 1, 1, 3);
        applyStimulus(0, 18'h0, 1, 0, 2);
        base = logB.size();
        applyStimulus(1, {8'h41, 8'h42, 2'b11}, 1, 0, 8);
        waitReady(100, "word2Ready");
        checkOutput("word2Addr", getLog(base), 9'h0C6);
        checkOutput("word2ChrA", getLog(base + 1), 9'h141);
        checkOutput("word2ChrB", getLog(base + 2), 9'h142);

        // Request edge and setLine together: the new line (0) applies.
        applyStimulus(0, 18'h0, 1, 0, 3);
        base = logB.size();
        applyStimulus(1, {8'h55, 8'hAA, 2'b00}, 0, 1, 2);
        applyStimulus(1, {8'h55, 8'hAA, 2'b00}, 0, 0, 6);
        waitReady(100, "word3Ready");
        checkOutput("word3Addr", getLog(base), 9'h080);
        checkOutput("word3ChrA", getLog(base + 1), 9'h155);
        checkOutput("word3ChrB", getLog(base + 2), 9'h1AA);

        // Second request edge while a word is in flight is dropped.
        applyStimulus(0, 18'h0, 0, 0, 3);
        base = logB.size();
        applyStimulus(1, {8'h31, 8'h32, 2'b10}, 0, 0, 1);
        waitEnable(20, "word4Started");
        applyStimulus(0, {8'h31, 8'h32, 2'b10}, 0, 0, 2);
        applyStimulus(1, {8'h31, 8'h32, 2'b10}, 0, 0, 1);
        waitReady(100, "word4Ready");
        repeat (10) @(negedge clk);
        checkOutput("busyDropCount", logB.size(), base + 3);
        checkOutput("word4Addr", getLog(base), 9'h084);

        // lcdWrite held high for 500 cycles gives exactly one word.
        applyStimulus(0, 18'h0, 0, 0, 3);
        base = logB.size();
        applyStimulus(1, {8'h48, 8'h49, 2'b00}, 0, 0, 500);
        checkOutput("holdCount", logB.size(), base + 3);
        checkOutput("holdReady", ready, 1);

        // Reset asserted while E is high drops E at once; init then repeats.
        applyStimulus(0, 18'h0, 0, 0, 3);
        applyStimulus(1, {8'h20, 8'h21, 2'b01}, 0, 0, 1);
        waitEnable(20, "preResetE");
        rstBt = 1'b0;
        #1;
        checkOutput("asyncE", enableOut, 0);
        checkOutput("asyncBusy", busy, 1);
        checkOutput("asyncReady", ready, 0);
        repeat (3) @(negedge clk);
        lcdWrite = 1'b0;
        base  = logB.size();
        rstBt = 1'b1;
        repeat (10) @(negedge clk);
        waitReady(400, "reinitReady");
        checkOutput("reinit0", getLog(base), 9'h038);
        checkOutput("reinit1", getLog(base + 1), 9'h00C);
        checkOutput("reinit2", getLog(base + 2), 9'h001);
        checkOutput("reinit3", getLog(base + 3), 9'h006);
        checkOutput("reinitFirstE", getCyc(base), 152);
        checkOutput("reinitReadyCycle", readyRise, 185);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
